// File: rtl/keypad_if.sv
// Signals between the matrix keypad scanner, the keypad lines and the game logic.
// The master side is the scanner; the slave side is the keypad and its consumer.
interface keypad_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
);
  logic            enable;
  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_out;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;
  logic            multi_key;

  modport master (
    input  enable, col_in,
    output row_out, key_code, key_valid, key_held, multi_key
  );
  modport slave (
    output enable, col_in,
    input  row_out, key_code, key_valid, key_held, multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: idles with all rows driven, wakes on column activity,
// sweeps rows one-hot and debounces whole-sweep results into key events.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 3,
  parameter int KW       = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input logic      clk_sec,
  input logic      rst,
  keypad_if.master kp
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(SETTLE);
  localparam int SW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, SCAN, EVAL} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;

  // Adds the set bits of one row sample to the sweep hit count, clamped at 2.
  function automatic logic [1:0] sat_hits(input logic [1:0] acc, input logic [COLS-1:0] v);
    int n;
    n = int'(acc);
    for (int i = 0; i < COLS; i++) n += int'(v[i]);
    return (n >= 2) ? 2'd2 : 2'(n);
  endfunction

  function automatic int lowest_col(input logic [COLS-1:0] v);
    int idx;
    idx = 0;
    for (int i = COLS - 1; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction

  logic [COLS-1:0] col_meta_p0, col_s;
  state_t          state, state_nx;
  logic [RW-1:0]   row_idx, row_nx;
  logic [DW-1:0]   dwell, dwell_nx;
  logic [1:0]      hits, hits_nx;
  logic [KW-1:0]   first_code, first_code_nx;
  res_t            cand_cls, cand_cls_nx, res_cls;
  logic [KW-1:0]   cand_code, cand_code_nx, res_code;
  logic [SW-1:0]   stable_cnt, stable_nx;
  logic            match, accept;
  logic [KW-1:0]   key_code, key_code_nx;
  logic            key_valid, key_valid_nx;
  logic            key_held, key_held_nx;
  logic            multi_key, multi_key_nx;
  logic [ROWS-1:0] row_drive;

  // Stage p0 -> col_s: two-flop synchroniser for the asynchronous column lines
  always_ff @(posedge clk_sec) begin
    col_meta_p0 <= kp.col_in;
    col_s       <= col_meta_p0;
  end

  always_ff @(posedge clk_sec or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row_idx    <= '0;
      dwell      <= '0;
      hits       <= '0;
      first_code <= '0;
      cand_cls   <= RES_NONE;
      cand_code  <= '0;
      stable_cnt <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      multi_key  <= 1'b0;
    end else begin
      state      <= state_nx;
      row_idx    <= row_nx;
      dwell      <= dwell_nx;
      hits       <= hits_nx;
      first_code <= first_code_nx;
      cand_cls   <= cand_cls_nx;
      cand_code  <= cand_code_nx;
      stable_cnt <= stable_nx;
      key_code   <= key_code_nx;
      key_valid  <= key_valid_nx;
      key_held   <= key_held_nx;
      multi_key  <= multi_key_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    row_nx        = row_idx;
    dwell_nx      = dwell;
    hits_nx       = hits;
    first_code_nx = first_code;
    cand_cls_nx   = cand_cls;
    cand_code_nx  = cand_code;
    stable_nx     = stable_cnt;
    key_code_nx   = key_code;
    key_valid_nx  = 1'b0;
    key_held_nx   = key_held;
    multi_key_nx  = multi_key;
    row_drive     = '1;
    res_cls       = (hits == 2'd0) ? RES_NONE : (hits == 2'd1) ? RES_SINGLE : RES_MULTI;
    res_code      = (res_cls == RES_SINGLE) ? first_code : '0;
    match         = (res_cls == cand_cls) && (res_code == cand_code);
    accept        = 1'b0;

    case (state)
      IDLE: begin
        if (kp.enable && |col_s) begin
          state_nx      = SCAN;
          row_nx        = '0;
          dwell_nx      = '0;
          hits_nx       = '0;
          first_code_nx = '0;
        end
      end
      SCAN: begin
        row_drive = ROWS'(1) << row_idx;
        if (dwell == DW'(SETTLE - 1)) begin
          hits_nx = sat_hits(hits, col_s);
          // Only the first hit of the sweep (lowest row, lowest column) names the key
          if (hits == 2'd0 && |col_s)
            first_code_nx = KW'(int'(row_idx) * COLS + lowest_col(col_s));
          dwell_nx = '0;
          if (row_idx == RW'(ROWS - 1)) state_nx = EVAL;
          else                          row_nx   = row_idx + RW'(1);
        end else begin
          dwell_nx = dwell + DW'(1);
        end
      end
      EVAL: begin
        if (match) begin
          stable_nx = (stable_cnt == SW'(DEBOUNCE)) ? stable_cnt : stable_cnt + SW'(1);
        end else begin
          cand_cls_nx  = res_cls;
          cand_code_nx = res_code;
          stable_nx    = SW'(1);
        end
        // Accept on the transition into full stability; a new candidate restarts the count
        accept = (stable_nx == SW'(DEBOUNCE)) && (!match || stable_cnt != SW'(DEBOUNCE));
        if (accept) begin
          case (res_cls)
            RES_SINGLE: begin
              key_code_nx  = res_code;
              key_valid_nx = 1'b1;
              key_held_nx  = 1'b1;
              multi_key_nx = 1'b0;
            end
            RES_MULTI: multi_key_nx = 1'b1;
            default: begin
              key_held_nx  = 1'b0;
              multi_key_nx = 1'b0;
            end
          endcase
        end
        if (cand_cls_nx == RES_NONE && stable_nx == SW'(DEBOUNCE)) begin
          state_nx = IDLE;
        end else begin
          state_nx      = SCAN;
          row_nx        = '0;
          dwell_nx      = '0;
          hits_nx       = '0;
          first_code_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Disabling abandons any debounce in progress; the last key code is kept
    if (!kp.enable) begin
      state_nx     = IDLE;
      cand_cls_nx  = RES_NONE;
      cand_code_nx = '0;
      stable_nx    = '0;
      key_valid_nx = 1'b0;
      key_held_nx  = 1'b0;
      multi_key_nx = 1'b0;
    end
  end

  assign kp.row_out   = row_drive;
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = key_held;
  assign kp.multi_key = multi_key;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: default 4x4 build plus a 3x5 build,
// each driven by a simple matrix model closing row-to-column contacts.
module tb_keypad_scanner;
  logic        clk_sec = 1'b0;
  logic        rst;
  logic [15:0] press_a;
  logic [14:0] press_b;
  int          errors = 0;
  int          checks = 0;
  int          pulses, first, second, heldz;

  always #5 clk_sec = ~clk_sec;

  keypad_if #(.ROWS(4), .COLS(4), .KW(4)) kpa ();
  keypad_if #(.ROWS(3), .COLS(5), .KW(4)) kpb ();

  keypad_scanner #(.ROWS(4), .COLS(4), .SETTLE(4), .DEBOUNCE(3), .KW(4)) dut_a (
    .clk_sec (clk_sec),
    .rst     (rst),
    .kp      (kpa)
  );
  keypad_scanner #(.ROWS(3), .COLS(5), .SETTLE(3), .DEBOUNCE(2), .KW(4)) dut_b (
    .clk_sec (clk_sec),
    .rst     (rst),
    .kp      (kpb)
  );

  // A pressed key connects its row line to its column line
  always_comb begin
    kpa.col_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_a[r*4+c] && kpa.row_out[r]) kpa.col_in[c] = 1'b1;
  end

  always_comb begin
    kpb.col_in = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        if (press_b[r*5+c] && kpb.row_out[r]) kpb.col_in[c] = 1'b1;
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected row drive k cycles into a wake-up: IDLE, 4 rows x 4 cycles, EVAL
  function automatic logic [3:0] row_exp(input int k);
    if (k == 0 || k == 17) return 4'hF;
    return 4'(1) << ((k - 1) / 4);
  endfunction

  initial begin
    rst = 1'b1;
    press_a = '0;
    press_b = '0;
    kpa.enable = 1'b0;
    kpb.enable = 1'b0;
    repeat (3) @(negedge clk_sec);
    check("rst_row_a", kpa.row_out, 4'hF);
    check("rst_code_a", kpa.key_code, 0);
    check("rst_valid_a", kpa.key_valid, 0);
    check("rst_held_a", kpa.key_held, 0);
    check("rst_multi_a", kpa.multi_key, 0);
    check("rst_row_b", kpb.row_out, 3'h7);
    rst = 1'b0;
    kpa.enable = 1'b1;
    kpb.enable = 1'b1;
    repeat (4) @(negedge clk_sec);

    // Single key 9 held, released at cycle 70
    press_a = 16'h0200;
    pulses = 0; first = 0;
    for (int i = 1; i <= 125; i++) begin
      @(negedge clk_sec);
      if (i == 70) press_a = '0;
      if (kpa.key_valid) begin pulses++; if (first == 0) first = i; end
      if (i >= 2 && i <= 19) check("t1_row", kpa.row_out, row_exp(i - 2));
      if (i == 60)  begin check("t1_code", kpa.key_code, 9); check("t1_held", kpa.key_held, 1); end
      if (i == 121) check("t1_held_before_rel", kpa.key_held, 1);
      if (i == 122) check("t1_held_after_rel", kpa.key_held, 0);
      if (i == 123) check("t1_idle_row", kpa.row_out, 4'hF);
      if (i == 125) check("t1_code_kept", kpa.key_code, 9);
    end
    check("t1_pulses", pulses, 1);
    check("t1_pulse_at", first, 54);

    // Key 5 pressed for two sweeps only
    @(negedge clk_sec);
    press_a = 16'h0020;
    pulses = 0; heldz = 0;
    for (int i = 1; i <= 95; i++) begin
      @(negedge clk_sec);
      if (i == 36) press_a = '0;
      if (kpa.key_valid) pulses++;
      if (kpa.key_held) heldz++;
      if (i == 71) check("t2_scan_row0", kpa.row_out, 4'h1);
      if (i == 86) check("t2_scan_row3", kpa.row_out, 4'h8);
      if (i == 89) check("t2_idle_row", kpa.row_out, 4'hF);
      if (i == 90) check("t2_code", kpa.key_code, 9);
    end
    check("t2_pulses", pulses, 0);
    check("t2_held_cycles", heldz, 0);

    // Keys 0 and 15 together
    @(negedge clk_sec);
    press_a = 16'h8001;
    pulses = 0;
    for (int i = 1; i <= 125; i++) begin
      @(negedge clk_sec);
      if (i == 70) press_a = '0;
      if (kpa.key_valid) pulses++;
      if (i == 53)  check("t3_multi_early", kpa.multi_key, 0);
      if (i == 54)  check("t3_multi_set", kpa.multi_key, 1);
      if (i == 60)  begin check("t3_code", kpa.key_code, 9); check("t3_held", kpa.key_held, 0); end
      if (i == 121) check("t3_multi_hold", kpa.multi_key, 1);
      if (i == 122) check("t3_multi_clr", kpa.multi_key, 0);
      if (i == 123) check("t3_idle_row", kpa.row_out, 4'hF);
    end
    check("t3_pulses", pulses, 0);

    // Roll-over from key 5 to key 6
    @(negedge clk_sec);
    press_a = 16'h0020;
    pulses = 0; first = 0; second = 0; heldz = 0;
    for (int i = 1; i <= 195; i++) begin
      @(negedge clk_sec);
      if (i == 70)  press_a = 16'h0040;
      if (i == 138) press_a = '0;
      if (kpa.key_valid) begin
        pulses++;
        if (first == 0) first = i; else if (second == 0) second = i;
      end
      if (i >= 54 && i <= 189 && !kpa.key_held) heldz++;
      if (i == 60)  check("t4_code5", kpa.key_code, 5);
      if (i == 122) check("t4_code6", kpa.key_code, 6);
      if (i == 190) check("t4_held_rel", kpa.key_held, 0);
    end
    check("t4_pulses", pulses, 2);
    check("t4_pulse1_at", first, 54);
    check("t4_pulse2_at", second, 122);
    check("t4_held_gaps", heldz, 0);

    // Asynchronous reset during row 2 of a sweep
    @(negedge clk_sec);
    press_a = 16'h0200;
    for (int i = 1; i <= 63; i++) begin
      @(negedge clk_sec);
      if (i == 62) check("t5_held_pre", kpa.key_held, 1);
      if (i == 63) check("t5_row2_pre", kpa.row_out, 4'h4);
    end
    rst = 1'b1;
    #1;
    check("t5_row", kpa.row_out, 4'hF);
    check("t5_valid", kpa.key_valid, 0);
    check("t5_held", kpa.key_held, 0);
    check("t5_multi", kpa.multi_key, 0);
    check("t5_code", kpa.key_code, 0);
    @(negedge clk_sec);
    rst = 1'b0;
    check("t5_idle_row", kpa.row_out, 4'hF);
    pulses = 0; first = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk_sec);
      if (kpa.key_valid) begin pulses++; if (first == 0) first = i; end
    end
    check("t5_pulses", pulses, 1);
    check("t5_latency_ok", (first >= 52 && first <= 54) ? 1 : 0, 1);
    check("t5_code_after", kpa.key_code, 9);
    press_a = '0;
    repeat (80) @(negedge clk_sec);
    check("t5_rel_held", kpa.key_held, 0);

    // Enable dropped mid-debounce, then restored with the key still down
    press_a = 16'h0200;
    pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_sec);
      if (kpa.key_valid) pulses++;
      if (i == 40) kpa.enable = 1'b0;
      if (i == 41) check("t6_idle_row", kpa.row_out, 4'hF);
      if (i == 45) check("t6_idle_row_late", kpa.row_out, 4'hF);
    end
    check("t6_no_pulse", pulses, 0);
    kpa.enable = 1'b1;
    pulses = 0; first = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_sec);
      if (kpa.key_valid) begin pulses++; if (first == 0) first = i; end
    end
    check("t6_pulses", pulses, 1);
    check("t6_pulse_at", first, 52);
    press_a = '0;

    // 3x5 build, SETTLE 3, DEBOUNCE 2, key 14
    @(negedge clk_sec);
    press_b = 15'h4000;
    pulses = 0; first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_sec);
      if (kpb.key_valid) begin pulses++; if (first == 0) first = i; end
      if (i == 3)  check("t7_row0", kpb.row_out, 3'h1);
      if (i == 6)  check("t7_row1", kpb.row_out, 3'h2);
      if (i == 11) check("t7_row2", kpb.row_out, 3'h4);
      if (i == 12) check("t7_eval_row", kpb.row_out, 3'h7);
      if (i == 30) begin check("t7_code", kpb.key_code, 14); check("t7_held", kpb.key_held, 1); end
    end
    check("t7_pulses", pulses, 1);
    check("t7_pulse_at", first, 23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner for the ColorMix keypad path. It idles with all rows driven and wakes on any column activity. It then sweeps the rows one-hot, samples the columns, debounces whole-sweep results and emits one key code per debounced press, with held and multi-key status. It replaces fixed 4-row free-running row drivers, and its outputs feed the game-logic FSM directly.

## Interface
- ROWS, default 4: number of row lines driven (≥2).
- COLS, default 4: number of column lines sampled (≥2).
- SETTLE, default 4: cycles each row is driven per sweep (≥3, covers the input synchroniser).
- DEBOUNCE, default 3: identical consecutive sweep results required to accept a state (≥1).
- KW, derived: $clog2(ROWS*COLS), minimum 1.

Ports:
- clk_sec  in  1  scan clock; every flop is clocked on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- enable  in  1  scanning enabled; low forces IDLE.
- col_in  in  COLS  raw column lines, active-high, asynchronous.
- row_out  out  ROWS  row drive, active-high.
- key_code  out  KW  last accepted key, encoded as row*COLS + col.
- key_valid  out  1  one-cycle pulse when a new single key is accepted.
- key_held  out  1  an accepted key is currently pressed.
- multi_key  out  1  debounced state is two or more keys pressed.

## Operation
- col_in passes through a 2-flop synchroniser to col_s. All column references below mean col_s.
- Reset values: state IDLE, row_out all ones, key_code 0, key_valid 0, key_held 0, multi_key 0. Row index, dwell counter, candidate and stable count are all 0.
- FSM states: IDLE, SCAN, EVAL.
- IDLE:
  - row_out all ones.
  - enable && |col_s → SCAN, starting at row 0 with dwell 0.
- SCAN:
  - row_out = one-hot(row), bit 0 = row 0.
  - dwell counts 0..SETTLE-1. At dwell SETTLE-1, col_s is sampled into the sweep accumulator.
  - Accumulator: total set bits across the sweep (saturating at 2), and the first hit code = row*COLS + lowest set column of the lowest hit row.
  - After sampling row ROWS-1 → EVAL. Otherwise advance to row+1 and reset dwell to 0.
- EVAL (one cycle):
  - row_out all ones.
  - Sweep result is NONE (0 hits), SINGLE(code), or MULTI (≥2 hits).
  - If the result equals the candidate (class and code), stable count increments, saturating at DEBOUNCE. Otherwise candidate ← result and stable count ← 1.
  - Acceptance occurs when the stable count becomes DEBOUNCE this cycle, i.e. it was below DEBOUNCE before.
    - SINGLE: key_code ← code, key_valid ← 1, key_held ← 1, multi_key ← 0.
    - MULTI: multi_key ← 1; key_code and key_held unchanged; no pulse.
    - NONE: key_held ← 0, multi_key ← 0.
  - A SINGLE result with a new code while a key is held (roll-over) is accepted as a fresh press, producing a new pulse and code.
  - Next state: IDLE if the accepted/candidate result is NONE with stable count = DEBOUNCE; otherwise SCAN at row 0.
- enable low (any state): next cycle → IDLE. Candidate and stable count clear; key_held and multi_key clear; no pulse. key_code holds its value.
- rst asserted mid-sweep: all outputs take their reset values immediately, without waiting for a clock edge.

## Timing
- Sweep length is ROWS*SETTLE + 1 cycles, which is 17 with defaults.
- key_valid is registered. It is high only during the cycle after the accepting EVAL and never lasts more than 1 cycle.
- Press latency, from the first IDLE cycle seeing |col_s = 1 (cycle t):
  - SCAN starts at t+1.
  - The k-th EVAL occurs at t + k*(ROWS*SETTLE+1).
  - key_valid is high at t + DEBOUNCE*(ROWS*SETTLE+1) + 1, which is t+52 with defaults.
- Release latency: DEBOUNCE NONE sweeps after the last pressed sweep. key_held falls the cycle after that EVAL, and IDLE is entered on the same edge.
- Raw col_in to col_s delay is 2 cycles. SETTLE ≥ 3 guarantees the sample reflects the driven row.

## Test plan
- Defaults, key at row 2 / col 1 held steady → key_code = 9, and exactly one key_valid pulse at t+52. key_held = 1 until release. row_out sequence is 1111, then 0001, 0010, 0100, 1000 (4 cycles each), then 1111 (EVAL).
- Press lasting 2 sweeps, then release → no key_valid, key_held stays 0, and the block returns to IDLE after 3 NONE sweeps.
- Keys row 0/col 0 and row 3/col 3 together, held → multi_key = 1 after 3 sweeps, no pulse, key_code unchanged. On release, multi_key → 0.
- Roll-over from key 5 held to key 6 without a gap → pulse with code 5, then after 3 stable sweeps a pulse with code 6. key_held stays 1 throughout.
- rst pulse during row 2 of a sweep → row_out = 1111 and key_valid/key_held/multi_key = 0 with no clock edge. Scanning restarts from IDLE.
- enable dropped mid-debounce → IDLE next cycle, no pulse. Re-enabling with the key still pressed restarts the full 52-cycle latency.
- ROWS=3, COLS=5, SETTLE=3, DEBOUNCE=2, key at row 2 / col 4 → key_code = 14, and the pulse arrives at t + 2*10 + 1 = t+21.
